// File: rtl/unidad_busqueda_pkg.sv
// Processor-wide definitions shared by the fetch stage and its next-PC logic.
package unidad_busqueda_pkg;

  localparam int unsigned ROM_DEPTH_DEF = 32;
  localparam int unsigned INSTR_W       = 32;
  localparam int unsigned OPC_W         = 6;

  localparam logic [OPC_W-1:0]   OPC_JUMP = 6'b111110;
  localparam logic [OPC_W-1:0]   OPC_LW   = 6'b100011;
  localparam logic [OPC_W-1:0]   OPC_SW   = 6'b101011;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    ARRANQUE = 1'b0,
    CORRE    = 1'b1
  } estado_t;

  // How the PC moves this cycle.
  typedef enum logic [1:0] {
    K_SEQ   = 2'd0,
    K_JUMP  = 2'd1,
    K_HOLD  = 2'd2,
    K_REDIR = 2'd3
  } kind_t;

endpackage

// File: rtl/unidad_busqueda_calc_siguiente_pc.sv
// Combinational next-PC selection: redirect > stall > local jump > sequential.
module calc_siguiente_pc
  import unidad_busqueda_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = ROM_DEPTH_DEF,
  parameter int unsigned PC_W      = 32
) (
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instru,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
  output logic [PC_W-1:0]    pc_next,
  output kind_t              kind
);

  localparam logic [PC_W-1:0] MASK = PC_W'(ROM_DEPTH - 1);

  logic [PC_W-1:0] w_pc_plus1;
  logic [PC_W-1:0] w_imm_sext;
  logic            w_is_jump;
  logic            w_unused_bits;

  assign w_pc_plus1    = pc + PC_W'(1);
  assign w_imm_sext    = {{(PC_W-16){instru[15]}}, instru[15:0]};
  assign w_is_jump     = (instru[31:26] == OPC_JUMP);
  assign w_unused_bits = ^instru[25:16];

  // Priority mux; every result is folded into the ROM address range.
  always_comb begin
    pc_next = pc;
    kind    = K_SEQ;
    if (redirect) begin
      pc_next = redirect_target & MASK;
      kind    = K_REDIR;
    end else if (stall) begin
      pc_next = pc;
      kind    = K_HOLD;
    end else if (w_is_jump) begin
      pc_next = (w_pc_plus1 + w_imm_sext) & MASK;
      kind    = K_JUMP;
    end else begin
      pc_next = w_pc_plus1 & MASK;
      kind    = K_SEQ;
    end
  end

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, fetch counter.
module unidad_busqueda
  import unidad_busqueda_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = ROM_DEPTH_DEF,
  parameter int unsigned PC_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instru,
  output logic [PC_W-1:0]    direinstru,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc_plus1,
  output logic               if_id_valid,
  output logic [31:0]        fetch_count
);

  localparam logic [PC_W-1:0] MASK = PC_W'(ROM_DEPTH - 1);

  estado_t             r_state, w_state_next;
  logic [PC_W-1:0]     r_pc, w_pc_next;
  logic [INSTR_W-1:0]  w_instr_next;
  logic [PC_W-1:0]     w_ifpc_next, w_plus1_next;
  logic                w_valid_next;
  logic [31:0]         w_count_next;
  logic [PC_W-1:0]     w_pc_calc;
  kind_t               w_kind;
  logic                w_running;

  // Stall/redirect are only honoured once running; the first edge is a plain fetch of 0.
  assign w_running = (r_state == CORRE);

  calc_siguiente_pc #(
    .ROM_DEPTH (ROM_DEPTH),
    .PC_W      (PC_W)
  ) u_calc (
    .pc              (r_pc),
    .instru          (instru),
    .stall           (stall & w_running),
    .redirect        (redirect & w_running),
    .redirect_target (redirect_target),
    .pc_next         (w_pc_calc),
    .kind            (w_kind)
  );

  // ROM address held at 0 during reset so the ROM sees a stable address.
  assign direinstru = reset ? '0 : r_pc;

  // Next-state and IF/ID update selection.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = if_id_instr;
    w_ifpc_next  = if_id_pc;
    w_plus1_next = if_id_pc_plus1;
    w_valid_next = if_id_valid;
    w_count_next = fetch_count;

    unique case (r_state)
      ARRANQUE: w_state_next = CORRE;
      CORRE:    w_state_next = CORRE;
      default:  w_state_next = ARRANQUE;
    endcase

    unique case (w_kind)
      K_REDIR: begin
        w_pc_next    = w_pc_calc;
        w_instr_next = NOP_WORD;
        w_ifpc_next  = '0;
        w_plus1_next = PC_W'(1);
        w_valid_next = 1'b0;
      end
      K_HOLD: begin
        w_pc_next = r_pc;
      end
      default: begin
        w_pc_next    = w_pc_calc;
        w_instr_next = instru;
        w_ifpc_next  = r_pc;
        w_plus1_next = (r_pc + PC_W'(1)) & MASK;
        w_valid_next = 1'b1;
        w_count_next = fetch_count + 32'd1;
      end
    endcase
  end

  // State, PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ARRANQUE;
      r_pc           <= '0;
      if_id_instr    <= NOP_WORD;
      if_id_pc       <= '0;
      if_id_pc_plus1 <= PC_W'(1);
      if_id_valid    <= 1'b0;
      fetch_count    <= 32'd0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      if_id_instr    <= w_instr_next;
      if_id_pc       <= w_ifpc_next;
      if_id_pc_plus1 <= w_plus1_next;
      if_id_valid    <= w_valid_next;
      fetch_count    <= w_count_next;
    end
  end

endmodule

// File: tb/tb_unidad_busqueda.sv
// Testbench for unidad_busqueda: directed plan steps followed by randomized checks against a reference model.
module tb_unidad_busqueda;

  localparam int unsigned DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instru;
  logic [31:0] direinstru;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus1;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  logic [31:0] rom [DEPTH];
  logic [4:0]  rom_addr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int unsigned m_pc, m_ifpc, m_plus1, m_cnt;
  logic [31:0] m_instr;
  logic        m_valid;

  assign rom_addr = direinstru[4:0];
  assign instru   = rom[rom_addr];

  always #5 clk = ~clk;

  unidad_busqueda #(.ROM_DEPTH(DEPTH), .PC_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .instru          (instru),
    .direinstru      (direinstru),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus1  (if_id_pc_plus1),
    .if_id_valid     (if_id_valid),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: one edge of the fetch stage, stated with plain integer arithmetic.
  task automatic model_edge(input logic st, input logic rd, input logic [31:0] tg);
    logic [31:0] w;
    int          nxt;
    w = rom[m_pc];
    if (rd) begin
      m_pc    = tg % DEPTH;
      m_valid = 1'b0;
      m_instr = 32'h0;
    end else if (!st) begin
      m_instr = w;
      m_ifpc  = m_pc;
      m_plus1 = (m_pc + 1) % DEPTH;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 1;
      if (w[31:26] == 6'b111110) begin
        nxt  = int'(m_pc) + 1 + int'($signed(w[15:0]));
        m_pc = int'(((nxt % int'(DEPTH)) + int'(DEPTH)) % int'(DEPTH));
      end else begin
        m_pc = (m_pc + 1) % DEPTH;
      end
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ifpc = 0; m_plus1 = 1; m_cnt = 0; m_instr = 32'h0; m_valid = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".dir"},   direinstru,  32'(m_pc));
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(m_valid));
    chk({tag, ".instr"}, if_id_instr, m_instr);
    chk({tag, ".cnt"},   fetch_count, 32'(m_cnt));
    if (m_valid) begin
      chk({tag, ".pc"},    if_id_pc,       32'(m_ifpc));
      chk({tag, ".plus1"}, if_id_pc_plus1, 32'(m_plus1));
    end
  endtask

  initial begin
    // Program image: sequential words, a +2 jump at address 8.
    for (int i = 0; i < int'(DEPTH); i++) rom[i] = 32'h0000_0100 + 32'(i);
    rom[0] = 32'hAC23_0000;
    rom[1] = 32'h8C3F_0000;
    rom[8] = 32'hF800_0002;

    // Reset for two edges; address gated to 0 while reset is high.
    reset = 1'b1;
    #1;
    chk("rst_dir_gate", direinstru, 32'd0);
    tick(); tick();
    chk("rst_dir",   direinstru,  32'd0);
    chk("rst_instr", if_id_instr, 32'd0);
    chk("rst_pc",    if_id_pc,    32'd0);
    chk("rst_plus1", if_id_pc_plus1, 32'd1);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_cnt",   fetch_count, 32'd0);

    // First fetch after release.
    reset = 1'b0;
    tick();
    chk("f0_dir",   direinstru,  32'd1);
    chk("f0_instr", if_id_instr, 32'hAC23_0000);
    chk("f0_pc",    if_id_pc,    32'd0);
    chk("f0_valid", 32'(if_id_valid), 32'd1);
    chk("f0_cnt",   fetch_count, 32'd1);
    tick();
    chk("f1_instr", if_id_instr, 32'h8C3F_0000);
    chk("f1_dir",   direinstru,  32'd2);
    tick(); tick();
    chk("pre_stall_dir", direinstru, 32'd4);

    // Stall three cycles at pc=4.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_dir",   direinstru,  32'd4);
      chk("stall_ifpc",  if_id_pc,    32'd3);
      chk("stall_instr", if_id_instr, rom[3]);
      chk("stall_cnt",   fetch_count, 32'd4);
    end
    stall = 1'b0;
    tick();
    chk("unstall_dir",   direinstru,  32'd5);
    chk("unstall_ifpc",  if_id_pc,    32'd4);
    chk("unstall_instr", if_id_instr, rom[4]);
    chk("unstall_cnt",   fetch_count, 32'd5);

    // Run to pc=8 and take the local jump.
    tick(); tick(); tick();
    chk("pre_jump_dir", direinstru, 32'd8);
    tick();
    chk("jump_dir",   direinstru,     32'd11);
    chk("jump_instr", if_id_instr,    32'hF800_0002);
    chk("jump_pc",    if_id_pc,       32'd8);
    chk("jump_plus1", if_id_pc_plus1, 32'd9);
    chk("jump_valid", 32'(if_id_valid), 32'd1);
    chk("jump_cnt",   fetch_count,    32'd9);

    // Redirect beats stall; target masked.
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'd37;
    tick();
    chk("redir_dir",   direinstru,  32'd5);
    chk("redir_valid", 32'(if_id_valid), 32'd0);
    chk("redir_instr", if_id_instr, 32'd0);
    chk("redir_cnt",   fetch_count, 32'd9);
    stall = 1'b0; redirect_target = 32'd31;
    tick();
    chk("redir31_dir", direinstru, 32'd31);
    redirect = 1'b0;

    // Sequential wrap from 31 to 0.
    tick();
    chk("wrap_dir",   direinstru,     32'd0);
    chk("wrap_pc",    if_id_pc,       32'd31);
    chk("wrap_plus1", if_id_pc_plus1, 32'd0);
    chk("wrap_cnt",   fetch_count,    32'd10);

    // Negative jump from 0 wraps to 31.
    rom[0] = 32'hF800_FFFE;
    tick();
    chk("negjump_dir",   direinstru,  32'd31);
    chk("negjump_instr", if_id_instr, 32'hF800_FFFE);
    chk("negjump_cnt",   fetch_count, 32'd11);
    rom[0] = 32'hAC23_0000;

    // Mid-run reset at pc=6.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("pre_rst_dir", direinstru, 32'd6);
    chk("pre_rst_cnt", fetch_count, 32'd6);
    reset = 1'b1;
    tick();
    chk("midrst_dir",   direinstru,  32'd0);
    chk("midrst_valid", 32'(if_id_valid), 32'd0);
    chk("midrst_cnt",   fetch_count, 32'd0);
    reset = 1'b0;
    tick();
    chk("resume_dir",   direinstru,  32'd1);
    chk("resume_pc",    if_id_pc,    32'd0);
    chk("resume_instr", if_id_instr, 32'hAC23_0000);
    chk("resume_cnt",   fetch_count, 32'd1);

    // Randomized program and control against the reference model.
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ($urandom_range(0, 3) == 0)
        rom[i] = {6'b111110, 10'($urandom), 16'(int'($urandom_range(0, 15)) - 8)};
      else
        rom[i] = {6'($urandom_range(0, 61)), 26'($urandom)};
    end
    reset = 1'b1; tick(); tick();
    model_reset();
    chk_model("rnd_rst");
    reset = 1'b0;
    tick();
    model_edge(1'b0, 1'b0, 32'd0);
    chk_model("rnd_first");
    for (int c = 0; c < 400; c++) begin
      stall           = ($urandom_range(0, 4) == 0);
      redirect        = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom;
      tick();
      model_edge(stall, redirect, redirect_target);
      chk_model("rnd");
    end
    stall = 1'b0; redirect = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/unidad_busqueda.md
Name: unidad_busqueda

Overview:
- Instruction-fetch (IF) stage of the segmented processor.
- Owns the program counter and drives the word address into the instruction ROM (memoriaintrucciones). Takes the returned instruction and registers it into the IF/ID pipeline register for decode.
- Resolves unconditional relative jumps locally, in IF. Accepts stall from the hazard unit and redirect/flush from later stages.

Parameters:
- ROM_DEPTH, 32, number of instruction words; the PC wraps modulo this value (power of two required).
- PC_W, 32, width of PC and address bus.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- instru  in  32  instruction word returned by ROM for direinstru (combinational, same cycle).
- direinstru  out  PC_W  current PC, word address into ROM.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- redirect  in  1  later stage overrides the PC; IF/ID is flushed.
- redirect_target  in  PC_W  new PC when redirect=1.
- if_id_instr  out  32  registered instruction.
- if_id_pc  out  PC_W  PC of if_id_instr.
- if_id_pc_plus1  out  PC_W  (if_id_pc+1) mod ROM_DEPTH.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_count  out  32  number of instructions loaded into IF/ID with valid=1.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - pc=0, if_id_instr=NOP (32'h0000_0000), if_id_pc=0, if_id_pc_plus1=1, if_id_valid=0, fetch_count=0.
  - direinstru=0 while reset is high, so the ROM init address is stable.
- States:
  - ARRANQUE: entered on reset. First edge with reset=0 goes to CORRE and performs a normal fetch of address 0.
  - CORRE: normal operation; remains here until reset.
  - A reset asserted mid-operation returns to ARRANQUE from any state and discards everything in flight.
- Latency: the instruction at direinstru=A appears on if_id_instr one edge later, with if_id_pc=A.
- Next-PC priority per edge in CORRE, highest first:
  1. redirect=1: pc <= redirect_target mod ROM_DEPTH; IF/ID <= NOP, valid=0. Overrides stall; no count increment.
  2. stall=1: pc, IF/ID and fetch_count all hold.
  3. Local jump, instru[31:26]==6'b111110: pc <= (pc + 1 + sext(instru[15:0])) mod ROM_DEPTH. The jump word itself is loaded into IF/ID with valid=1 and is counted.
  4. Otherwise: pc <= (pc+1) mod ROM_DEPTH; IF/ID <= {instru, pc}, valid=1; fetch_count+1.
- Arithmetic and wrap:
  - All PC arithmetic is in PC_W bits, then masked to log2(ROM_DEPTH) bits with upper bits zero.
  - pc=ROM_DEPTH-1 sequential fetch -> 0.
  - Negative jump from 0 wraps, e.g. imm=-2 at pc=0 -> 31.
- fetch_count wraps at 2^32 with no saturation.
- redirect and local jump in the same cycle: redirect wins; the jump word is squashed (valid=0).
- redirect_target beyond ROM_DEPTH is masked, e.g. 37 -> 5 with ROM_DEPTH=32.

Decomposition:
- Shared package (processor-wide):
  - OPC_JUMP=6'b111110, OPC_LW=6'b100011, OPC_SW=6'b101011.
  - NOP word 32'h0000_0000.
  - ROM_DEPTH default.
  - Enum for states ARRANQUE/CORRE.
- One sub-module, calc_siguiente_pc: combinational next-PC mux. Inputs pc, instru, stall, redirect, redirect_target. Outputs pc_next and kind {SEQ, JUMP, HOLD, REDIR}.
- The top level holds the PC register, IF/ID register, state and counter.

Test Plan:
- ROM loaded per current image, reset 2 cycles, release -> first edge: direinstru 0->1, if_id_instr=32'hAC230000, if_id_pc=0, valid=1, fetch_count=1; next edge if_id_instr=32'h8C3F0000.
- Run to pc=8 holding 32'hF8000002 -> next edge direinstru=11, if_id_instr=32'hF8000002, if_id_pc=8, if_id_pc_plus1=9, valid=1.
- stall=1 for 3 cycles at pc=4 -> direinstru stays 4, IF/ID and fetch_count unchanged; release -> pc=5, IF/ID holds word 4.
- stall=1 and redirect=1, target=37, same cycle -> direinstru=5, if_id_valid=0, if_id_instr=0, fetch_count unchanged.
- pc=31 sequential (non-jump word) -> direinstru=0, if_id_pc=31, if_id_pc_plus1=0. Jump imm=16'hFFFE at pc=0 -> direinstru=31.
- reset=1 for one edge while pc=6, valid=1, fetch_count=6 -> direinstru=0, if_id_valid=0, fetch_count=0; fetch resumes from 0 after release.
